// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the axi_ram slave.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Anything other than FIXED/INCR is executed as INCR but flagged.
  function automatic logic burst_err(input logic [1:0] burst);
    return (burst != FIXED) && (burst != INCR);
  endfunction

endpackage

// File: rtl/axi_ram_if.sv
// AXI4 memory-mapped port between the pass-through stage (master) and axi_ram (slave).
interface axi_ram_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [ID_WIDTH-1:0]     awid;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache, awqos, awprot;
  logic                    awlock, awvalid, awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [ID_WIDTH-1:0]     arid;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arcache, arqos, arprot;
  logic                    arlock, arvalid, arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [DATA_WIDTH/8-1:0] rstrb;
  logic [ID_WIDTH-1:0]     rid;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport master (
    output awaddr, awlen, awid, awsize, awburst, awcache, awqos, awprot, awlock, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arlen, arid, arsize, arburst, arcache, arqos, arprot, arlock, arvalid,
    input  arready,
    input  rdata, rstrb, rid, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awid, awsize, awburst, awcache, awqos, awprot, awlock, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arlen, arid, arsize, arburst, arcache, arqos, arprot, arlock, arvalid,
    output arready,
    output rdata, rstrb, rid, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_ram_bram_be.sv
// Simple dual-port RAM: byte-enabled write port, registered read port that holds
// its output while re is low (old data on a same-address read/write).
module bram_be #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4096,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (we && wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // NOTE: non-blocking on both ports makes a same-cycle read see the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_ram.sv
// AXI4 RAM slave: independent write and read FSMs in front of a byte-enabled BRAM,
// one outstanding burst per direction, all handshake/response outputs registered.
module axi_ram
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  axi_ram_if.slave axim
);

  localparam int         STRB_W    = DATA_WIDTH / 8;
  localparam int         OFFS      = $clog2(STRB_W);
  localparam int         IDX_W     = ADDR_WIDTH - OFFS;
  localparam logic [2:0] SIZE_FULL = 3'(OFFS);

  // ---------------- write channel ----------------
  wr_state_t          wr_state;
  logic [IDX_W-1:0]   w_idx;
  logic [7:0]         w_len, w_cnt;
  logic [ID_WIDTH-1:0] w_id;
  logic               w_fixed, w_err;

  logic aw_hs, w_hs, w_last_beat, w_beat_err;
  assign aw_hs       = axim.awvalid & axim.awready;
  assign w_hs        = axim.wvalid & axim.wready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = (axim.wlast != w_last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state     <= W_IDLE;
      axim.awready <= 1'b0;
      axim.wready  <= 1'b0;
      axim.bvalid  <= 1'b0;
      axim.bid     <= '0;
      axim.bresp   <= RESP_OKAY;
      w_idx        <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      w_id         <= '0;
      w_fixed      <= 1'b0;
      w_err        <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          axim.awready <= !aw_hs;
          if (aw_hs) begin
            w_idx       <= axim.awaddr[ADDR_WIDTH-1:OFFS];
            w_len       <= axim.awlen;
            w_cnt       <= '0;
            w_id        <= axim.awid;
            w_fixed     <= (axim.awburst == FIXED);
            w_err       <= burst_err(axim.awburst) || (axim.awsize != SIZE_FULL);
            axim.wready <= 1'b1;
            wr_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed)  w_idx <= w_idx + IDX_W'(1);
            if (w_beat_err) w_err <= 1'b1;
            // The beat count, not wlast, closes the burst.
            if (w_last_beat) begin
              axim.wready <= 1'b0;
              axim.bvalid <= 1'b1;
              axim.bid    <= w_id;
              axim.bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              wr_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axim.bready) begin
            axim.bvalid  <= 1'b0;
            axim.awready <= 1'b1;
            wr_state     <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_t           rd_state;
  logic [IDX_W-1:0]    r_idx, r_next_idx, ram_raddr;
  logic [7:0]          r_len, r_cnt;
  logic                r_fixed, ram_re;

  logic ar_hs, r_hs;
  assign ar_hs      = axim.arvalid & axim.arready;
  assign r_hs       = axim.rvalid & axim.rready;
  assign r_next_idx = r_fixed ? r_idx : r_idx + IDX_W'(1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = r_next_idx;
    if (ar_hs) begin
      ram_re    = 1'b1;
      ram_raddr = axim.araddr[ADDR_WIDTH-1:OFFS];
    end else if (r_hs && !axim.rlast) begin
      ram_re    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state     <= R_IDLE;
      axim.arready <= 1'b0;
      axim.rvalid  <= 1'b0;
      axim.rlast   <= 1'b0;
      axim.rid     <= '0;
      axim.rresp   <= RESP_OKAY;
      r_idx        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_fixed      <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          axim.arready <= !ar_hs;
          if (ar_hs) begin
            r_idx       <= axim.araddr[ADDR_WIDTH-1:OFFS];
            r_len       <= axim.arlen;
            r_cnt       <= '0;
            r_fixed     <= (axim.arburst == FIXED);
            axim.rid    <= axim.arid;
            axim.rresp  <= (burst_err(axim.arburst) || (axim.arsize != SIZE_FULL))
                           ? RESP_SLVERR : RESP_OKAY;
            axim.rvalid <= 1'b1;
            axim.rlast  <= (axim.arlen == 8'd0);
            rd_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (axim.rlast) begin
              axim.rvalid  <= 1'b0;
              axim.rlast   <= 1'b0;
              axim.arready <= 1'b1;
              rd_state     <= R_IDLE;
            end else begin
              r_idx      <= r_next_idx;
              r_cnt      <= r_cnt + 8'd1;
              axim.rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign axim.rstrb = '1;

  bram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (1 << IDX_W)
  ) u_bram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_hs),
    .waddr (w_idx),
    .wdata (axim.wdata),
    .wbe   (axim.wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (axim.rdata)
  );

  // Sideband attributes and sub-word address bits carry no meaning for this RAM.
  logic unused_sideband;
  assign unused_sideband = &{1'b0, axim.awcache, axim.awqos, axim.awprot, axim.awlock,
                             axim.arcache, axim.arqos, axim.arprot, axim.arlock,
                             axim.awaddr[OFFS-1:0], axim.araddr[OFFS-1:0]};

endmodule

// File: tb/tb_axi_ram.sv
// Directed bench for axi_ram: shadow-memory model feeds B and R scoreboards.
module tb_axi_ram;
  import axi_pkg::*;

  localparam int DW = 128;
  localparam int AW = 16;
  localparam int IW = 4;
  localparam int SB = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axim ();

  axi_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk  (clk),
    .rst  (rst),
    .axim (axim)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  b_exp_t        b_q[$];
  r_exp_t        r_q[$];
  logic [DW-1:0] model [4096];
  logic [DW-1:0] wd [8];
  logic [SB-1:0] ws [8];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [15:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                             input logic [2:0] size, input logic [1:0] burst, input bit bad_last);
    logic [11:0] idx;
    b_exp_t      be, got;
    int          n;
    idx     = addr[15:4];
    be.id   = id;
    be.resp = ((burst == WRAP) || (size != 3'd4) || bad_last) ? RESP_SLVERR : RESP_OKAY;
    b_q.push_back(be);
    axim.awaddr = addr; axim.awlen = len; axim.awid = id; axim.awsize = size; axim.awburst = burst;
    axim.awvalid = 1'b1;
    n = 0;
    while (axim.awready !== 1'b1 && n < 100) begin tick(); n++; end
    check("aw_timeout", n < 100, 1'b1);
    tick();
    axim.awvalid = 1'b0;
    check("wready_after_aw", axim.wready, 1'b1);
    for (int b = 0; b <= int'(len); b++) begin
      for (int k = 0; k < SB; k++) if (ws[b][k]) model[idx][k*8 +: 8] = wd[b][k*8 +: 8];
      axim.wdata  = wd[b];
      axim.wstrb  = ws[b];
      axim.wlast  = bad_last ? (b == 0) : (b == int'(len));
      axim.wvalid = 1'b1;
      n = 0;
      while (axim.wready !== 1'b1 && n < 100) begin tick(); n++; end
      tick();
      if (burst != FIXED) idx++;
    end
    axim.wvalid = 1'b0;
    axim.wlast  = 1'b0;
    check("bvalid_after_last", axim.bvalid, 1'b1);
    axim.bready = 1'b1;
    n = 0;
    while (axim.bvalid !== 1'b1 && n < 100) begin tick(); n++; end
    got = b_q.pop_front();
    check("bid", axim.bid, got.id);
    check("bresp", axim.bresp, got.resp);
    tick();
    axim.bready = 1'b0;
    check("bvalid_drop", axim.bvalid, 1'b0);
  endtask

  task automatic read_burst(input logic [15:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                            input logic [2:0] size, input logic [1:0] burst, input bit stall);
    logic [11:0]   idx;
    r_exp_t        e;
    logic [DW-1:0] hd;
    logic          hl;
    int            n, b, cyc;
    idx = addr[15:4];
    for (int i = 0; i <= int'(len); i++) begin
      e.data = model[idx];
      e.id   = id;
      e.resp = ((burst == WRAP) || (size != 3'd4)) ? RESP_SLVERR : RESP_OKAY;
      e.last = (i == int'(len));
      r_q.push_back(e);
      if (burst != FIXED) idx++;
    end
    axim.araddr = addr; axim.arlen = len; axim.arid = id; axim.arsize = size; axim.arburst = burst;
    axim.arvalid = 1'b1;
    n = 0;
    while (axim.arready !== 1'b1 && n < 100) begin tick(); n++; end
    check("ar_timeout", n < 100, 1'b1);
    tick();
    axim.arvalid = 1'b0;
    check("rvalid_after_ar", axim.rvalid, 1'b1);
    b = 0;
    cyc = 0;
    while (b <= int'(len) && cyc < 50) begin
      axim.rready = !(stall && cyc == 1);
      check("rvalid", axim.rvalid, 1'b1);
      if (axim.rready) begin
        e = r_q.pop_front();
        check("rdata", axim.rdata, e.data);
        check("rid", axim.rid, e.id);
        check("rresp", axim.rresp, e.resp);
        check("rlast", axim.rlast, e.last);
        b++;
        tick();
      end else begin
        hd = axim.rdata;
        hl = axim.rlast;
        tick();
        check("rdata_hold", axim.rdata, hd);
        check("rlast_hold", axim.rlast, hl);
      end
      cyc++;
    end
    check("read_beats", b, int'(len) + 1);
    axim.rready = 1'b0;
    check("rvalid_drop", axim.rvalid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] old_word;
    b_exp_t        got;
    for (int i = 0; i < 4096; i++) model[i] = '0;
    axim.awaddr = '0; axim.awlen = '0; axim.awid = '0; axim.awsize = 3'd4; axim.awburst = INCR;
    axim.awcache = '0; axim.awqos = '0; axim.awprot = '0; axim.awlock = 1'b0; axim.awvalid = 1'b0;
    axim.wdata = '0; axim.wstrb = '0; axim.wlast = 1'b0; axim.wvalid = 1'b0; axim.bready = 1'b0;
    axim.araddr = '0; axim.arlen = '0; axim.arid = '0; axim.arsize = 3'd4; axim.arburst = INCR;
    axim.arcache = '0; axim.arqos = '0; axim.arprot = '0; axim.arlock = 1'b0; axim.arvalid = 1'b0;
    axim.rready = 1'b0;

    // Reset state and release timing
    repeat (3) tick();
    check("rst_awready", axim.awready, 1'b0);
    check("rst_arready", axim.arready, 1'b0);
    check("rst_wready", axim.wready, 1'b0);
    check("rst_bvalid", axim.bvalid, 1'b0);
    check("rst_rvalid", axim.rvalid, 1'b0);
    check("rst_rdata", axim.rdata, '0);
    rst = 1'b0;
    #1;
    check("awready_before_edge", axim.awready, 1'b0);
    tick();
    check("awready_after_rel", axim.awready, 1'b1);
    check("arready_after_rel", axim.arready, 1'b1);

    // 1: single beat
    wd[0] = {96'h0, 32'hDEADBEEF}; ws[0] = '1;
    write_burst(16'h0010, 8'd0, 4'd3, 3'd4, INCR, 1'b0);
    read_burst(16'h0010, 8'd0, 4'd3, 3'd4, INCR, 1'b0);

    // 2: INCR burst wrapping past the top word
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = '1; end
    write_burst(16'hFFE0, 8'd3, 4'd1, 3'd4, INCR, 1'b0);
    read_burst(16'hFFE0, 8'd3, 4'd1, 3'd4, INCR, 1'b0);
    read_burst(16'h0000, 8'd1, 4'd2, 3'd4, INCR, 1'b0);

    // 3: FIXED burst with per-beat strobes over a known background
    wd[0] = {16{8'hA5}}; ws[0] = '1;
    write_burst(16'h0100, 8'd0, 4'd4, 3'd4, INCR, 1'b0);
    for (int i = 0; i < 3; i++) begin wd[i] = {16{8'(8'h11 * (i + 1))}}; ws[i] = SB'(1) << i; end
    write_burst(16'h0100, 8'd2, 4'd4, 3'd4, FIXED, 1'b0);
    read_burst(16'h0100, 8'd0, 4'd4, 3'd4, INCR, 1'b0);

    // 4: error responses
    for (int i = 0; i < 4; i++) begin wd[i] = {4{32'h5000_0000 + 32'(i)}}; ws[i] = '1; end
    write_burst(16'h0500, 8'd3, 4'd8, 3'd4, WRAP, 1'b0);
    write_burst(16'h0600, 8'd1, 4'd9, 3'd0, INCR, 1'b0);
    write_burst(16'h0700, 8'd1, 4'd10, 3'd4, INCR, 1'b1);
    read_burst(16'h0500, 8'd3, 4'd11, 3'd4, WRAP, 1'b0);

    // 5a: stalled read concurrent with a write elsewhere
    for (int i = 0; i < 4; i++) begin wd[i] = {4{32'h4000_0000 + 32'(i)}}; ws[i] = '1; end
    write_burst(16'h0400, 8'd3, 4'd5, 3'd4, INCR, 1'b0);
    for (int i = 0; i < 4; i++) wd[i] = {4{32'h8000_0000 + 32'(i)}};
    fork
      read_burst(16'h0400, 8'd3, 4'd5, 3'd4, INCR, 1'b1);
      write_burst(16'h0800, 8'd3, 4'd6, 3'd4, INCR, 1'b0);
    join
    read_burst(16'h0800, 8'd3, 4'd6, 3'd4, INCR, 1'b0);

    // 5b: same-word write and read in the same cycle
    wd[0] = {4{32'hCAFEF00D}}; ws[0] = '1;
    write_burst(16'h0200, 8'd0, 4'd7, 3'd4, INCR, 1'b0);
    old_word = model[12'h020];
    axim.awaddr = 16'h0200; axim.awlen = 8'd0; axim.awid = 4'd7; axim.awsize = 3'd4; axim.awburst = INCR;
    axim.awvalid = 1'b1;
    tick();
    axim.awvalid = 1'b0;
    check("same_wready", axim.wready, 1'b1);
    check("same_arready", axim.arready, 1'b1);
    axim.wdata = {4{32'h0BADC0DE}}; axim.wstrb = '1; axim.wlast = 1'b1; axim.wvalid = 1'b1;
    axim.araddr = 16'h0200; axim.arlen = 8'd0; axim.arid = 4'd7; axim.arsize = 3'd4; axim.arburst = INCR;
    axim.arvalid = 1'b1;
    tick();
    axim.wvalid = 1'b0; axim.wlast = 1'b0; axim.arvalid = 1'b0;
    model[12'h020] = {4{32'h0BADC0DE}};
    check("same_rvalid", axim.rvalid, 1'b1);
    check("same_old_data", axim.rdata, old_word);
    check("same_bvalid", axim.bvalid, 1'b1);
    axim.rready = 1'b1; axim.bready = 1'b1;
    tick();
    axim.rready = 1'b0; axim.bready = 1'b0;
    read_burst(16'h0200, 8'd0, 4'd7, 3'd4, INCR, 1'b0);

    // 6: reset after 2 of 4 beats
    axim.awaddr = 16'h0300; axim.awlen = 8'd3; axim.awid = 4'd12; axim.awsize = 3'd4; axim.awburst = INCR;
    axim.awvalid = 1'b1;
    tick();
    axim.awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      axim.wdata = {4{32'h3000_0000 + 32'(b)}}; axim.wstrb = '1; axim.wlast = 1'b0; axim.wvalid = 1'b1;
      model[12'h030 + 12'(b)] = axim.wdata;
      tick();
    end
    rst = 1'b1;
    #1;
    axim.wvalid = 1'b0;
    check("midrst_wready", axim.wready, 1'b0);
    check("midrst_awready", axim.awready, 1'b0);
    check("midrst_arready", axim.arready, 1'b0);
    check("midrst_bvalid", axim.bvalid, 1'b0);
    check("midrst_rvalid", axim.rvalid, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_awready", axim.awready, 1'b1);
    repeat (3) tick();
    check("postrst_no_b", axim.bvalid, 1'b0);
    read_burst(16'h0300, 8'd1, 4'd12, 3'd4, INCR, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
